exec_unit: RTL

//  Sequenced execute stage wrapped around the 8x16 register file.

---
 rtl/exec_pkg.sv | 29 ++
 rtl/exec_alu.sv | 51 +++++
 rtl/exec_unit.sv | 130 +++++++++++++
 3 files changed

// File: rtl/exec_pkg.sv
// Shared types and defaults for the sequenced execute stage.
package exec_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_NREGS = 8;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_MVN = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_LSL1 = 2'b01,
    SH_LSR1 = 2'b10,
    SH_ASR1 = 2'b11
  } shift_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD_A = 3'd1,
    ST_RD_B = 3'd2,
    ST_EXEC = 3'd3,
    ST_WB   = 3'd4
  } state_e;

endpackage

// File: rtl/exec_alu.sv
// Combinational B-operand shifter, ALU and status flag generation.
module exec_alu
  import exec_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_e          op,
  input  shift_e           shift,
  output logic [WIDTH-1:0] c,
  output logic             z,
  output logic             n,
  output logic             v
);

  logic [WIDTH-1:0] bs;

  always_comb begin
    bs = b;
    case (shift)
      SH_LSL1: bs = {b[WIDTH-2:0], 1'b0};
      SH_LSR1: bs = {1'b0, b[WIDTH-1:1]};
      SH_ASR1: bs = {b[WIDTH-1], b[WIDTH-1:1]};
      default: bs = b;
    endcase
  end

  // Overflow only when the result sign disagrees with what the operand signs allow.
  always_comb begin
    c = '0;
    v = 1'b0;
    case (op)
      ALU_ADD: begin
        c = a + bs;
        v = (a[WIDTH-1] == bs[WIDTH-1]) && (c[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        c = a - bs;
        v = (a[WIDTH-1] != bs[WIDTH-1]) && (c[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_AND: c = a & bs;
      ALU_MVN: c = ~bs;
      default: c = '0;
    endcase
  end

  assign z = (c == '0);
  assign n = c[WIDTH-1];

endmodule

// File: rtl/exec_unit.sv
// Five-state execute sequencer: read Rn, read Rm, execute, write back to the regfile.
module exec_unit
  import exec_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREGS = DEF_NREGS,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_alu_op,
  input  logic [1:0]       in_shift,
  input  logic [AW-1:0]    in_rn,
  input  logic [AW-1:0]    in_rm,
  input  logic [AW-1:0]    in_rd,
  input  logic             in_wb,
  output logic [AW-1:0]    rf_readnum,
  input  logic [WIDTH-1:0] rf_data_out,
  output logic [AW-1:0]    rf_writenum,
  output logic             rf_write,
  output logic [WIDTH-1:0] rf_data_in,
  output logic [WIDTH-1:0] out_c,
  output logic             status_z,
  output logic             status_n,
  output logic             status_v,
  output logic             done
);

  state_e           state, state_nx;
  alu_op_e          op_q;
  shift_e           shift_q;
  logic [AW-1:0]    rn_q, rm_q, rd_q;
  logic             wb_q;
  logic [WIDTH-1:0] a_q, b_q, c_q;
  logic             z_q, n_q, v_q;
  logic [WIDTH-1:0] alu_c;
  logic             alu_z, alu_n, alu_v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    in_ready    = 1'b0;
    rf_readnum  = '0;
    rf_write    = 1'b0;
    done        = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = ST_RD_A;
      end
      ST_RD_A: begin
        rf_readnum = rn_q;
        state_nx   = ST_RD_B;
      end
      ST_RD_B: begin
        rf_readnum = rm_q;
        state_nx   = ST_EXEC;
      end
      ST_EXEC: state_nx = ST_WB;
      ST_WB: begin
        rf_write = wb_q;
        done     = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= ALU_ADD;
      shift_q <= SH_NONE;
      rn_q    <= '0;
      rm_q    <= '0;
      rd_q    <= '0;
      wb_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (in_valid) begin
          op_q    <= alu_op_e'(in_alu_op);
          shift_q <= shift_e'(in_shift);
          rn_q    <= in_rn;
          rm_q    <= in_rm;
          rd_q    <= in_rd;
          wb_q    <= in_wb;
        end
        ST_RD_A: a_q <= rf_data_out;
        ST_RD_B: b_q <= rf_data_out;
        ST_EXEC: begin
          c_q <= alu_c;
          z_q <= alu_z;
          n_q <= alu_n;
          v_q <= alu_v;
        end
        default: ;
      endcase
    end
  end

  exec_alu #(.WIDTH(WIDTH)) u_alu (
    .a     (a_q),
    .b     (b_q),
    .op    (op_q),
    .shift (shift_q),
    .c     (alu_c),
    .z     (alu_z),
    .n     (alu_n),
    .v     (alu_v)
  );

  assign rf_writenum = rd_q;
  assign rf_data_in  = c_q;
  assign out_c       = c_q;
  assign status_z    = z_q;
  assign status_n    = n_q;
  assign status_v    = v_q;

endmodule
